ascon_serial_ctrl: RTL

- Host-side sequencer for the bit-serial Ascon core.
- Accepts one parallel command (key, nonce, associated data, input data, direction) and shifts the operands into the core MSB-first.
- Pulses the core start and waits for core ready, with a timeout.
- Deserialises the output data and tag streams into parallel result registers, then presents them under a valid/ready handshake.

---
 rtl/ascon_serial_ctrl_if.sv | 28 ++
 rtl/ascon_serial_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ascon_serial_ctrl_if.sv
// Host-side command/result bundle for the serial Ascon sequencer.
// master = host driving commands, slave = controller.
interface ascon_serial_ctrl_if #(
    parameter int W = 128
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_decrypt;
    logic [W-1:0] key_i;
    logic [W-1:0] nonce_i;
    logic [W-1:0] ad_i;
    logic [W-1:0] data_i;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic [W-1:0] res_tag;
    logic         res_error;

    modport master (
        output cmd_valid, cmd_decrypt, key_i, nonce_i, ad_i, data_i, res_ready,
        input  cmd_ready, res_valid, res_data, res_tag, res_error
    );

    modport slave (
        input  cmd_valid, cmd_decrypt, key_i, nonce_i, ad_i, data_i, res_ready,
        output cmd_ready, res_valid, res_data, res_tag, res_error
    );
endinterface

// File: rtl/ascon_serial_ctrl.sv
// Sequencer: latch one parallel command, shift operands MSB-first into the serial core,
// pulse start, wait (with timeout) for ready, deserialise data/tag and hold them until res_ready.
module ascon_serial_ctrl #(
    parameter int W           = 128,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    ascon_serial_ctrl_if.slave  host,
    output logic                core_key_o,
    output logic                core_nonce_o,
    output logic                core_ad_o,
    output logic                core_data_o,
    output logic                core_start_o,
    output logic                core_decrypt_o,
    input  logic                core_out_i,
    input  logic                core_tag_i,
    input  logic                core_ready_i
);
    localparam int MAXV = (W > TIMEOUT_CYC) ? W : TIMEOUT_CYC;
    localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_UNLOAD, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] cnt;
    logic [W-1:0]  key_q, nonce_q, ad_q, data_q;
    logic          dec_q;
    logic [W-1:0]  res_data_q, res_tag_q;
    logic          res_error_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        host.cmd_ready = 1'b0;
        host.res_valid = 1'b0;
        core_key_o     = 1'b0;
        core_nonce_o   = 1'b0;
        core_ad_o      = 1'b0;
        core_data_o    = 1'b0;
        core_start_o   = 1'b0;
        core_decrypt_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                host.cmd_ready = 1'b1;
                if (host.cmd_valid) state_d = S_LOAD;
            end
            S_LOAD: begin
                // operand registers shift left, so the MSB is always the bit due this cycle
                core_key_o     = key_q[W-1];
                core_nonce_o   = nonce_q[W-1];
                core_ad_o      = ad_q[W-1];
                core_data_o    = data_q[W-1];
                core_decrypt_o = dec_q;
                if (cnt == LAST_BIT) state_d = S_START;
            end
            S_START: begin
                core_start_o   = 1'b1;
                core_decrypt_o = dec_q;
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                core_decrypt_o = dec_q;
                if (core_ready_i)           state_d = S_UNLOAD;
                else if (cnt == LAST_WAIT)  state_d = S_DONE;
            end
            S_UNLOAD: begin
                core_decrypt_o = dec_q;
                if (cnt == LAST_BIT) state_d = S_DONE;
            end
            S_DONE: begin
                host.res_valid = 1'b1;
                core_decrypt_o = dec_q;
                if (host.res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            key_q       <= '0;
            nonce_q     <= '0;
            ad_q        <= '0;
            data_q      <= '0;
            dec_q       <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            res_error_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (host.cmd_valid) begin
                        key_q       <= host.key_i;
                        nonce_q     <= host.nonce_i;
                        ad_q        <= host.ad_i;
                        data_q      <= host.data_i;
                        dec_q       <= host.cmd_decrypt;
                        res_error_q <= 1'b0;
                        cnt         <= '0;
                    end
                end
                S_LOAD: begin
                    key_q   <= {key_q[W-2:0], 1'b0};
                    nonce_q <= {nonce_q[W-2:0], 1'b0};
                    ad_q    <= {ad_q[W-2:0], 1'b0};
                    data_q  <= {data_q[W-2:0], 1'b0};
                    cnt     <= (cnt == LAST_BIT) ? '0 : cnt + CW'(1);
                end
                S_START: cnt <= '0;
                S_WAIT: begin
                    if (core_ready_i) begin
                        // the exit cycle already carries the first (MSB) output bit
                        res_data_q <= {res_data_q[W-2:0], core_out_i};
                        res_tag_q  <= {res_tag_q[W-2:0], core_tag_i};
                        cnt        <= CW'(1);
                    end else if (cnt == LAST_WAIT) begin
                        res_error_q <= 1'b1;
                        res_data_q  <= '0;
                        res_tag_q   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_UNLOAD: begin
                    res_data_q <= {res_data_q[W-2:0], core_out_i};
                    res_tag_q  <= {res_tag_q[W-2:0], core_tag_i};
                    cnt        <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign host.res_data  = res_data_q;
    assign host.res_tag   = res_tag_q;
    assign host.res_error = res_error_q;
endmodule
